// File: rtl/counter_syn_pkg.sv
// Shared constants and parameter checks for the counter synchroniser family
// (single-bit, data and bus variants).
`timescale 1ns/1ps
package counter_syn_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int BUS_WIDTH_MIN   = 1;
  localparam int BUS_WIDTH_MAX   = 64;

  function automatic bit param_in_range(input int value, input int lo, input int hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/counter_bus_syn_if.sv
// Bus-side signals of counter_bus_syn; the master drives the source bus and
// the clear, the slave (the synchroniser) returns status and the synchronised bus.
`timescale 1ns/1ps
interface counter_bus_syn_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  logic [WIDTH-1:0] i_din;
  logic             i_drop_clr;
  logic             o_busy;
  logic [CNT_W-1:0] o_drop_cnt;
  logic [WIDTH-1:0] o_dout;
  logic             o_dout_vld;

  modport master (
    output i_din,
    output i_drop_clr,
    input  o_busy,
    input  o_drop_cnt,
    input  o_dout,
    input  o_dout_vld
  );

  modport slave (
    input  i_din,
    input  i_drop_clr,
    output o_busy,
    output o_drop_cnt,
    output o_dout,
    output o_dout_vld
  );

endinterface

// File: rtl/counter_sync_bits.sv
// N-bit flop-chain synchroniser into i_clk, STAGES deep, async active-low reset to 0.
// Only use on signals that change at most one bit at a time (toggles).
`timescale 1ns/1ps
module counter_sync_bits #(
  parameter int N      = 1,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    (* ASYNC_REG = "TRUE" *) logic [N-1:0] stage_q;

    if (gi == 0) begin : g_first
      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) stage_q <= '0;
        else         stage_q <= i_d;
      end
    end else begin : g_next
      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) stage_q <= '0;
        else         stage_q <= g_stage[gi-1].stage_q;
      end
    end
  end

  assign o_q = g_stage[STAGES-1].stage_q;

endmodule

// File: rtl/counter_bus_syn.sv
// Transfers a quasi-static WIDTH-bit level bus from i_clk_din to i_clk_dout with a
// toggle req/ack handshake; changes seen while a transfer is in flight are coalesced and counted.
`timescale 1ns/1ps
module counter_bus_syn
  import counter_syn_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = 8
) (
  input  logic               i_clk_din,
  input  logic               i_rstn_din,
  input  logic               i_clk_dout,
  input  logic               i_rstn_dout,
  counter_bus_syn_if.slave   bus
);

  if (!param_in_range(WIDTH, BUS_WIDTH_MIN, BUS_WIDTH_MAX) ||
      !param_in_range(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX) ||
      (CNT_W < 1)) begin : g_param_check
    $error("counter_bus_syn: WIDTH, SYNC_STAGES or CNT_W out of range");
  end

  localparam logic [CNT_W-1:0] DROP_MAX = '1;

  // ---------------- din domain ----------------
  // hold_q -> dout_q must be constrained as a multicycle/false path: hold_q is
  // frozen from launch until the matching ack is back in the din domain.
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] din_dly_q;
  logic             req_q, req_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             ack_sync;
  logic             busy;
  logic             launch;
  logic             drop_inc;

  always_comb begin
    busy       = req_q ^ ack_sync;
    launch     = !busy && (bus.i_din != hold_q);
    drop_inc   = busy && (bus.i_din != din_dly_q);
    hold_d     = hold_q;
    req_d      = req_q;
    drop_cnt_d = drop_cnt_q;
    if (launch) begin
      hold_d = bus.i_din;
      req_d  = ~req_q;
    end
    if (bus.i_drop_clr) begin
      drop_cnt_d = '0;
    end else if (drop_inc && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk_din or negedge i_rstn_din) begin
    if (!i_rstn_din) begin
      hold_q     <= '0;
      req_q      <= 1'b0;
      din_dly_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      hold_q     <= hold_d;
      req_q      <= req_d;
      din_dly_q  <= bus.i_din;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.o_busy     = busy;
  assign bus.o_drop_cnt = drop_cnt_q;

  // ---------------- handshake synchronisers ----------------
  logic req_sync;
  logic ack_q, ack_d;

  counter_sync_bits #(
    .N      (1),
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .i_clk  (i_clk_dout),
    .i_rstn (i_rstn_dout),
    .i_d    (req_q),
    .o_q    (req_sync)
  );

  counter_sync_bits #(
    .N      (1),
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .i_clk  (i_clk_din),
    .i_rstn (i_rstn_din),
    .i_d    (ack_q),
    .o_q    (ack_sync)
  );

  // ---------------- dout domain ----------------
  logic             req_seen_q, req_seen_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             dout_event;

  always_comb begin
    dout_event = (req_sync != req_seen_q);
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    if (dout_event) begin
      dout_d     = hold_q;
      dout_vld_d = 1'b1;
      req_seen_d = req_sync;
      ack_d      = ~ack_q;
    end
  end

  always_ff @(posedge i_clk_dout or negedge i_rstn_dout) begin
    if (!i_rstn_dout) begin
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign bus.o_dout     = dout_q;
  assign bus.o_dout_vld = dout_vld_q;

endmodule

// File: tb/tb_counter_bus_syn.sv
// Directed and random checks of counter_bus_syn; every o_dout_vld is matched in order
// against a queue of values the bench drove onto i_din.
`timescale 1ns/1ps
module tb_counter_bus_syn;

  localparam int WIDTH = 8;
  localparam int SS    = 2;
  localparam int CNT_W = 3;

  logic    clk_din   = 1'b0;
  logic    clk_dout  = 1'b0;
  logic    rstn_din  = 1'b0;
  logic    rstn_dout = 1'b0;
  realtime din_half  = 5.0;
  realtime dout_half = 13.514;

  int checks   = 0;
  int failures = 0;
  int vld_cnt  = 0;

  logic [WIDTH-1:0] sb_q[$];
  logic             mon_hit;
  logic [WIDTH-1:0] mon_e;

  counter_bus_syn_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  counter_bus_syn #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SS),
    .CNT_W       (CNT_W)
  ) dut (
    .i_clk_din   (clk_din),
    .i_rstn_din  (rstn_din),
    .i_clk_dout  (clk_dout),
    .i_rstn_dout (rstn_dout),
    .bus         (bus)
  );

  always #(din_half)  clk_din  = ~clk_din;
  always #(dout_half) clk_dout = ~clk_dout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Each vld must show a value that was driven, in driving order (skips = coalesced values).
  always @(negedge clk_dout) begin
    if (bus.o_dout_vld === 1'b1) begin
      vld_cnt++;
      mon_hit = 1'b0;
      while (!mon_hit && sb_q.size() > 0) begin
        mon_e   = sb_q.pop_front();
        mon_hit = (mon_e === bus.o_dout);
      end
      $display("vld #%0d o_dout=0x%0h known=%0d", vld_cnt, bus.o_dout, mon_hit);
      check("sb_dout_launched", {63'b0, mon_hit}, 64'd1);
    end
  end

  task automatic din_cycles(input int n);
    repeat (n) @(negedge clk_din);
  endtask

  task automatic dout_cycles(input int n);
    repeat (n) @(negedge clk_dout);
  endtask

  task automatic settle(input string tag);
    int quiet  = 0;
    int budget = 4000;
    while (quiet < 4 && budget > 0) begin
      @(negedge clk_din);
      quiet = (bus.o_busy === 1'b0) ? quiet + 1 : 0;
      budget--;
    end
    check({tag, "_settled"}, 64'(quiet >= 4), 64'd1);
    dout_cycles(4);
  endtask

  task automatic wait_vld(input int target, input string tag);
    int budget = 200;
    while (vld_cnt < target && budget > 0) begin
      @(negedge clk_dout);
      budget--;
    end
    check({tag, "_vld_seen"}, 64'(vld_cnt >= target), 64'd1);
  endtask

  task automatic assert_resets(input logic [WIDTH-1:0] din_val);
    rstn_din       = 1'b0;
    rstn_dout      = 1'b0;
    bus.i_din      = din_val;
    bus.i_drop_clr = 1'b0;
    sb_q.delete();
    din_cycles(3);
    dout_cycles(2);
  endtask

  task automatic drive(input logic [WIDTH-1:0] v, input bit expect_out);
    @(negedge clk_din);
    bus.i_din = v;
    if (expect_out) sb_q.push_back(v);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    bit seen;
    logic [WIDTH-1:0] v;

    // ---- reset state, then power-on with a nonzero bus ----
    bus.i_din      = 8'hFF;
    bus.i_drop_clr = 1'b0;
    sb_q.push_back(8'hFF);
    din_cycles(3);
    dout_cycles(2);
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_drop_cnt", 64'(bus.o_drop_cnt), 64'd0);
    check("rst_dout", 64'(bus.o_dout), 64'd0);
    check("rst_dout_vld", 64'(bus.o_dout_vld), 64'd0);

    @(negedge clk_din);
    rstn_din  = 1'b1;
    rstn_dout = 1'b1;
    base = vld_cnt;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk_dout);
      n++;
      @(negedge clk_dout);
      seen = (bus.o_dout_vld === 1'b1);
    end
    check("pon_latency_in_range", 64'((n >= SS + 1) && (n <= SS + 2)), 64'd1);
    check("pon_dout", 64'(bus.o_dout), 64'hFF);
    settle("pon");
    check("pon_vld_count", 64'(vld_cnt - base), 64'd1);
    check("pon_drop_cnt", 64'(bus.o_drop_cnt), 64'd0);

    // ---- single update 0x00 -> 0x5A ----
    @(negedge clk_din);
    assert_resets(8'h00);
    check("rst2_dout", 64'(bus.o_dout), 64'd0);
    @(negedge clk_din);
    rstn_din  = 1'b1;
    rstn_dout = 1'b1;
    base = vld_cnt;
    dout_cycles(20);
    check("idle_no_vld", 64'(vld_cnt - base), 64'd0);
    check("idle_busy", 64'(bus.o_busy), 64'd0);

    base = vld_cnt;
    drive(8'h5A, 1'b1);
    wait_vld(base + 1, "single");
    settle("single");
    check("single_vld_count", 64'(vld_cnt - base), 64'd1);
    check("single_dout", 64'(bus.o_dout), 64'h5A);
    check("single_busy", 64'(bus.o_busy), 64'd0);
    check("single_drop_cnt", 64'(bus.o_drop_cnt), 64'd0);

    // ---- burst coalescing: 01,02,03,04 on consecutive cycles ----
    base = vld_cnt;
    drive(8'h01, 1'b1);
    drive(8'h02, 1'b0);
    drive(8'h03, 1'b0);
    drive(8'h04, 1'b1);
    settle("burst");
    check("burst_vld_count", 64'(vld_cnt - base), 64'd2);
    check("burst_dout", 64'(bus.o_dout), 64'h04);
    check("burst_drop_cnt", 64'(bus.o_drop_cnt), 64'd3);

    // ---- saturation: toggle every cycle for 20 cycles ----
    for (int i = 0; i < 20; i++) begin
      drive((i % 2 == 1) ? 8'hAA : 8'h55, 1'b1);
    end
    settle("sat");
    check("sat_drop_cnt", 64'(bus.o_drop_cnt), 64'd7);
    check("sat_dout", 64'(bus.o_dout), 64'hAA);
    check("sat_busy", 64'(bus.o_busy), 64'd0);

    @(negedge clk_din);
    bus.i_drop_clr = 1'b1;
    @(negedge clk_din);
    bus.i_drop_clr = 1'b0;
    check("clr_drop_cnt", 64'(bus.o_drop_cnt), 64'd0);

    // ---- clear coinciding with a counted change ----
    drive(8'h40, 1'b1);
    drive(8'h41, 1'b1);
    bus.i_drop_clr = 1'b1;
    @(negedge clk_din);
    bus.i_drop_clr = 1'b0;
    check("clr_inc_same_cycle", 64'(bus.o_drop_cnt), 64'd0);
    bus.i_din = 8'h42;
    sb_q.push_back(8'h42);
    @(negedge clk_din);
    check("inc_after_clr", 64'(bus.o_drop_cnt), 64'd1);
    settle("clrinc");
    check("clrinc_dout", 64'(bus.o_dout), 64'h42);

    // ---- reset one dout cycle after a launch ----
    @(negedge clk_din);
    bus.i_din = 8'h77;
    @(posedge clk_din);
    @(posedge clk_dout);
    @(negedge clk_dout);
    assert_resets(8'h00);
    check("midrst_dout", 64'(bus.o_dout), 64'd0);
    check("midrst_busy", 64'(bus.o_busy), 64'd0);
    @(negedge clk_din);
    rstn_din  = 1'b1;
    rstn_dout = 1'b1;
    base = vld_cnt;
    dout_cycles(30);
    check("midrst_no_vld", 64'(vld_cnt - base), 64'd0);
    check("midrst_dout_after", 64'(bus.o_dout), 64'd0);
    drive(8'h33, 1'b1);
    wait_vld(base + 1, "midrst");
    settle("midrst");
    check("midrst_vld_count", 64'(vld_cnt - base), 64'd1);
    check("midrst_dout_33", 64'(bus.o_dout), 64'h33);

    // ---- clock ratios with random held values ----
    for (int r = 0; r < 2; r++) begin
      @(negedge clk_din);
      din_half  = (r == 0) ? 5.0 : 50.0;
      dout_half = (r == 0) ? 50.0 : 5.0;
      dout_cycles(2);
      base = vld_cnt;
      v    = 8'h00;
      for (int k = 0; k < 500; k++) begin
        v = 8'($urandom_range(0, 255));
        drive(v, 1'b1);
        din_cycles(int'($urandom_range(0, 3)));
      end
      settle($sformatf("ratio%0d", r));
      check($sformatf("ratio%0d_last_dout", r), 64'(bus.o_dout), 64'(v));
      check($sformatf("ratio%0d_busy", r), 64'(bus.o_busy), 64'd0);
      check($sformatf("ratio%0d_some_vld", r), 64'(vld_cnt > base), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
